// File: rtl/linebuffer_pingpong_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : linebuffer_pingpong_ctrl
// Purpose  : Ping-pong scanline buffer between the PPU writer and video-out reader.
// Revision : 1.0 - initial release
// ============================================================================
module linebuffer_pingpong_ctrl #(
    parameter int                    DATA_WIDTH = 15,
    parameter int                    ADDR_WIDTH = 8,
    parameter int                    LINE_LEN   = 240,
    parameter logic [DATA_WIDTH-1:0] BLANK      = '0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  frame_start,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  rd_req,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_underrun,
    output logic [1:0]            lines_ready
);

    localparam int                  CW     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] W_LAST = ADDR_WIDTH'(LINE_LEN - 1);
    localparam logic [CW-1:0]       R_LAST = CW'(LINE_LEN - 1);
    localparam logic [CW-1:0]       R_LEN  = CW'(LINE_LEN);

    typedef enum logic [1:0] {B_FREE = 2'd0, B_FILL = 2'd1, B_FULL = 2'd2, B_READ = 2'd3} bank_e;
    typedef enum logic       {W_WAIT = 1'b0, W_FILL = 1'b1} wstate_e;
    typedef enum logic [1:0] {R_IDLE = 2'd0, R_STREAM = 2'd1, R_BLANK = 2'd2} rstate_e;

    bank_e                   bank_q [2];
    bank_e                   bank_d [2];
    wstate_e                 wstate_q, wstate_d;
    rstate_e                 rstate_q, rstate_d;
    logic [ADDR_WIDTH-1:0]   wcnt_q, wcnt_d;
    logic [CW-1:0]           rcnt_q, rcnt_d;
    logic                    fill_ptr_q, fill_ptr_d;
    logic                    read_ptr_q, read_ptr_d;
    logic                    rd_valid_q, rd_valid_d;
    logic                    rd_blank_q, rd_blank_d;
    logic                    rd_sel_q, rd_sel_d;
    logic                    rd_underrun_q, rd_underrun_d;
    logic [1:0]              lines_ready_q, lines_ready_d;
    logic                    wr_fire;
    logic                    rd_issue;
    logic [DATA_WIDTH-1:0]   bank_dout [2];

    assign wr_ready = (wstate_q == W_FILL) && !frame_start;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        wstate_d      = wstate_q;
        rstate_d      = rstate_q;
        wcnt_d        = wcnt_q;
        rcnt_d        = rcnt_q;
        fill_ptr_d    = fill_ptr_q;
        read_ptr_d    = read_ptr_q;
        rd_valid_d    = 1'b0;
        rd_blank_d    = 1'b0;
        rd_sel_d      = rd_sel_q;
        rd_underrun_d = 1'b0;
        rd_issue      = 1'b0;
        lines_ready_d = {1'b0, bank_q[0] == B_FULL} + {1'b0, bank_q[1] == B_FULL};

        if (frame_start) begin
            bank_d[0]     = B_FREE;
            bank_d[1]     = B_FREE;
            wstate_d      = W_WAIT;
            rstate_d      = R_IDLE;
            wcnt_d        = '0;
            rcnt_d        = '0;
            fill_ptr_d    = 1'b0;
            read_ptr_d    = 1'b0;
            rd_sel_d      = 1'b0;
            lines_ready_d = 2'd0;
        end else begin
            case (wstate_q)
                W_WAIT: begin
                    if (bank_q[fill_ptr_q] == B_FREE) begin
                        bank_d[fill_ptr_q] = B_FILL;
                        wstate_d           = W_FILL;
                    end
                end
                W_FILL: begin
                    if (wr_fire) begin
                        if (wcnt_q == W_LAST) begin
                            bank_d[fill_ptr_q] = B_FULL;
                            wcnt_d             = '0;
                            fill_ptr_d         = !fill_ptr_q;
                            wstate_d           = W_WAIT;
                        end else begin
                            wcnt_d = wcnt_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: wstate_d = W_WAIT;
            endcase

            // The writer only owns FREE/FILL banks and the reader only FULL/READ
            // banks, so the two bank_d updates below never target the same bank.
            case (rstate_q)
                R_IDLE: begin
                    rcnt_d = '0;
                    if (rd_req) begin
                        if (bank_q[read_ptr_q] == B_FULL) begin
                            bank_d[read_ptr_q] = B_READ;
                            rstate_d           = R_STREAM;
                        end else begin
                            rd_underrun_d = 1'b1;
                            rstate_d      = R_BLANK;
                        end
                    end
                end
                R_STREAM, R_BLANK: begin
                    if (rcnt_q < R_LEN) begin
                        rd_valid_d = 1'b1;
                        rd_blank_d = (rstate_q == R_BLANK);
                        rcnt_d     = rcnt_q + CW'(1);
                        if (rstate_q == R_STREAM) begin
                            rd_issue = 1'b1;
                            rd_sel_d = read_ptr_q;
                            if (rcnt_q == R_LAST) begin
                                bank_d[read_ptr_q] = B_FREE;
                                read_ptr_d         = !read_ptr_q;
                            end
                        end
                    end else begin
                        // One extra cycle lets the final pixel leave the RAM register.
                        rcnt_d   = '0;
                        rstate_d = R_IDLE;
                    end
                end
                default: rstate_d = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bank_q[0]     <= B_FREE;
            bank_q[1]     <= B_FREE;
            wstate_q      <= W_WAIT;
            rstate_q      <= R_IDLE;
            wcnt_q        <= '0;
            rcnt_q        <= '0;
            fill_ptr_q    <= 1'b0;
            read_ptr_q    <= 1'b0;
            rd_valid_q    <= 1'b0;
            rd_blank_q    <= 1'b0;
            rd_sel_q      <= 1'b0;
            rd_underrun_q <= 1'b0;
            lines_ready_q <= 2'd0;
        end else begin
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            wstate_q      <= wstate_d;
            rstate_q      <= rstate_d;
            wcnt_q        <= wcnt_d;
            rcnt_q        <= rcnt_d;
            fill_ptr_q    <= fill_ptr_d;
            read_ptr_q    <= read_ptr_d;
            rd_valid_q    <= rd_valid_d;
            rd_blank_q    <= rd_blank_d;
            rd_sel_q      <= rd_sel_d;
            rd_underrun_q <= rd_underrun_d;
            lines_ready_q <= lines_ready_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        localparam logic BANK_ID = 1'(b);
        logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
        logic [DATA_WIDTH-1:0] dout_q;

        always_ff @(posedge clk) begin
            if (wr_fire && (fill_ptr_q == BANK_ID)) begin
                mem[wcnt_q] <= wr_data;
            end
            if (rd_issue && (read_ptr_q == BANK_ID)) begin
                dout_q <= mem[rcnt_q[ADDR_WIDTH-1:0]];
            end
        end

        assign bank_dout[b] = dout_q;
    end

    assign rd_valid    = rd_valid_q;
    assign rd_data     = !rd_valid_q ? '0 : (rd_blank_q ? BLANK : bank_dout[rd_sel_q]);
    assign rd_underrun = rd_underrun_q;
    assign lines_ready = lines_ready_q;

endmodule
`default_nettype wire
